subtract_32: RTL and testbench

//  32-bit two's-complement subtractor for the KLP32 ALU: result = X - Y, plus a signed-overflow flag.

---
 rtl/subtract_32.sv | 77 +++++++
 tb/tb_subtract_32.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/subtract_32.sv
// 32-bit two's-complement subtractor (X - Y) via a ripple-carry X + ~Y + 1 chain, with registered copies.
// Optional flags (zero, negative, borrow and their registered copies) are enabled by defining SUB32_FLAGS_EN.
module subtract_32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
`ifdef SUB32_FLAGS_EN
  output logic             zero,
  output logic             negative,
  output logic             borrow,
  output logic             zero_q,
  output logic             negative_q,
  output logic             borrow_q,
`endif
  output logic [WIDTH-1:0] result_q,
  output logic             overflow_q
);

  logic [WIDTH:0]   carry_s;
  logic [WIDTH-1:0] y_inv_s;
  logic [WIDTH-1:0] sum_s;
  logic             ovf_s;

  assign y_inv_s = ~Y;

  // Ripple-carry chain for X + ~Y with the carry-in tied high
  always_comb begin
    carry_s    = {(WIDTH+1){1'b0}};
    sum_s      = {WIDTH{1'b0}};
    carry_s[0] = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      sum_s[i]     = X[i] ^ y_inv_s[i] ^ carry_s[i];
      carry_s[i+1] = (X[i] & y_inv_s[i]) | (carry_s[i] & (X[i] ^ y_inv_s[i]));
    end
  end

  // Overflow only when operand signs differ and the result sign departs from X
  assign ovf_s    = (X[WIDTH-1] != Y[WIDTH-1]) && (sum_s[WIDTH-1] != X[WIDTH-1]);
  assign result   = sum_s;
  assign overflow = ovf_s;

`ifdef SUB32_FLAGS_EN
  assign zero     = (sum_s == {WIDTH{1'b0}});
  assign negative = sum_s[WIDTH-1];
  assign borrow   = ~carry_s[WIDTH];
`else
  logic unused_carry_s;
  assign unused_carry_s = carry_s[WIDTH];
`endif

  // Pipeline copy of the combinational outputs, cleared by synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= {WIDTH{1'b0}};
      overflow_q <= 1'b0;
`ifdef SUB32_FLAGS_EN
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      borrow_q   <= 1'b0;
`endif
    end else begin
      result_q   <= sum_s;
      overflow_q <= ovf_s;
`ifdef SUB32_FLAGS_EN
      zero_q     <= zero;
      negative_q <= negative;
      borrow_q   <= borrow;
`endif
    end
  end

endmodule

// File: tb/tb_subtract_32.sv
// Self-checking bench for subtract_32: directed corner cases plus random operands against an arithmetic model.
module tb_subtract_32;

  logic        clk;
  logic        rst;
  logic [31:0] X;
  logic [31:0] Y;
  logic [31:0] result;
  logic        overflow;
  logic [31:0] result_q;
  logic        overflow_q;
`ifdef SUB32_FLAGS_EN
  logic        zero, negative, borrow;
  logic        zero_q, negative_q, borrow_q;
`endif

  int n_vec;
  int n_miss;

  subtract_32 dut (
    .clk        (clk),
    .rst        (rst),
    .X          (X),
    .Y          (Y),
    .result     (result),
    .overflow   (overflow),
`ifdef SUB32_FLAGS_EN
    .zero       (zero),
    .negative   (negative),
    .borrow     (borrow),
    .zero_q     (zero_q),
    .negative_q (negative_q),
    .borrow_q   (borrow_q),
`endif
    .result_q   (result_q),
    .overflow_q (overflow_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Arithmetic reference: plain subtraction and a wide signed range test
  function automatic logic [31:0] model_res(input logic [31:0] a, input logic [31:0] b);
    return a - b;
  endfunction

  function automatic logic model_ovf(input logic [31:0] a, input logic [31:0] b);
    longint d;
    d = longint'($signed(a)) - longint'($signed(b));
    return (d > 64'sd2147483647) || (d < -64'sd2147483648);
  endfunction

  task automatic apply_vec(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] er;
    logic        eo;
    X  = a;
    Y  = b;
    er = model_res(a, b);
    eo = model_ovf(a, b);
    #1;
    check("result", result, er);
    check("overflow", {31'd0, overflow}, {31'd0, eo});
`ifdef SUB32_FLAGS_EN
    check("zero", {31'd0, zero}, {31'd0, (er == 32'd0)});
    check("negative", {31'd0, negative}, {31'd0, ($signed(er) < 0)});
    check("borrow", {31'd0, borrow}, {31'd0, (a < b)});
`endif
    @(posedge clk);
    #1;
    check("result_q", result_q, er);
    check("overflow_q", {31'd0, overflow_q}, {31'd0, eo});
`ifdef SUB32_FLAGS_EN
    check("zero_q", {31'd0, zero_q}, {31'd0, (er == 32'd0)});
    check("borrow_q", {31'd0, borrow_q}, {31'd0, (a < b)});
`endif
  endtask

  logic [31:0] dx [11];
  logic [31:0] dy [11];
  logic [31:0] dr [11];
  logic        dovf [11];

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst    = 1'b1;
    X      = 32'd0;
    Y      = 32'd0;
    @(posedge clk);
    #1;
    check("reset_result_q", result_q, 32'd0);
    check("reset_overflow_q", {31'd0, overflow_q}, 32'd0);
    rst = 1'b0;

    dx[0] = 32'd0;          dy[0] = 32'd0;          dr[0] = 32'd0;          dovf[0] = 1'b0;
    dx[1] = 32'd1;          dy[1] = 32'd1;          dr[1] = 32'd0;          dovf[1] = 1'b0;
    dx[2] = 32'd0;          dy[2] = 32'd1;          dr[2] = 32'hFFFFFFFF;   dovf[2] = 1'b0;
    dx[3] = 32'd123456;     dy[3] = 32'd65432;      dr[3] = 32'd58024;      dovf[3] = 1'b0;
    dx[4] = 32'd65432;      dy[4] = 32'd123456;     dr[4] = 32'hFFFF1D58;   dovf[4] = 1'b0;
    dx[5] = 32'hFFFFFFF6;   dy[5] = 32'd20;         dr[5] = 32'hFFFFFFE2;   dovf[5] = 1'b0;
    dx[6] = 32'd20;         dy[6] = 32'hFFFFFFF6;   dr[6] = 32'd30;         dovf[6] = 1'b0;
    dx[7] = 32'hFFFFFFF6;   dy[7] = 32'hFFFFFFEC;   dr[7] = 32'd10;         dovf[7] = 1'b0;
    dx[8] = 32'h7FFFFFFF;   dy[8] = 32'h80000000;   dr[8] = 32'hFFFFFFFF;   dovf[8] = 1'b1;
    dx[9] = 32'h80000000;   dy[9] = 32'h7FFFFFFF;   dr[9] = 32'h00000001;   dovf[9] = 1'b1;
    dx[10] = 32'h80000000;  dy[10] = 32'd0;         dr[10] = 32'h80000000;  dovf[10] = 1'b0;

    for (int i = 0; i < 11; i++) begin
      X = dx[i];
      Y = dy[i];
      #1;
      check($sformatf("dir_result_%0d", i), result, dr[i]);
      check($sformatf("dir_ovf_%0d", i), {31'd0, overflow}, {31'd0, dovf[i]});
      apply_vec(dx[i], dy[i]);
    end

    // Reset wins on the registers but leaves the combinational path alone
    apply_vec(32'd5, 32'd3);
    check("pre_rst_result_q", result_q, 32'd2);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_result_q", result_q, 32'd0);
    check("rst_overflow_q", {31'd0, overflow_q}, 32'd0);
    check("rst_result_comb", result, 32'd2);
    rst = 1'b0;

    for (int i = 0; i < 10000; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = $urandom;
      if (i % 8 == 0) b = a ^ (32'h1 << $urandom_range(31, 0));
      if (i % 16 == 1) a = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'h7FFFFFFF};
      apply_vec(a, b);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
